// File: rtl/product_accumulator.sv
// Product accumulator: sums batches of 4x4 multiplier products
// and hands each batch total downstream over a valid/ready pair.
module product_accumulator (
  input  logic        clk,
  input  logic        reset,
  input  logic        prod_valid,
  input  logic [7:0]  prod_data,
  output logic        prod_ready,
  input  logic [3:0]  batch_len,
  input  logic        flush,
  output logic        sum_valid,
  output logic [11:0] sum_data,
  input  logic        sum_ready,
  output logic        busy
);

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t      state;
  logic [11:0] acc;
  logic [4:0]  count;
  logic [4:0]  len;

  logic        accept;
  logic [4:0]  eff_len;
  logic [4:0]  count_nxt;
  logic [11:0] acc_nxt;

  assign prod_ready = (state == ACC) && !flush;
  assign accept     = prod_valid && prod_ready;
  assign busy       = (state == DONE) || (count != 5'd0);

  // A zero batch_len encodes 16; length is frozen after the first product
  assign eff_len   = (count == 5'd0) ? {(batch_len == 4'd0), batch_len}
                                     : len;
  assign count_nxt = count + 5'd1;
  assign acc_nxt   = acc + {4'd0, prod_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ACC;
      acc       <= 12'd0;
      count     <= 5'd0;
      len       <= 5'd0;
      sum_valid <= 1'b0;
      sum_data  <= 12'd0;
    end else begin
      unique case (state)
        ACC: begin
          if (flush) begin
            acc   <= 12'd0;
            count <= 5'd0;
          end else if (accept) begin
            if (count == 5'd0)
              len <= eff_len;
            if (count_nxt == eff_len) begin
              sum_data  <= acc_nxt;
              sum_valid <= 1'b1;
              state     <= DONE;
              acc       <= 12'd0;
              count     <= 5'd0;
            end else begin
              acc   <= acc_nxt;
              count <= count_nxt;
            end
          end
        end
        DONE: begin
          if (sum_ready) begin
            sum_valid <= 1'b0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator with a scoreboard of
// expected batch sums filled as products are accepted.
module tb_product_accumulator;

  logic        clk;
  logic        reset;
  logic        prod_valid;
  logic [7:0]  prod_data;
  logic        prod_ready;
  logic [3:0]  batch_len;
  logic        flush;
  logic        sum_valid;
  logic [11:0] sum_data;
  logic        sum_ready;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int q[$];
  int macc = 0;
  int mcnt = 0;
  int mlen = 0;

  product_accumulator dut (
    .clk        (clk),
    .reset      (reset),
    .prod_valid (prod_valid),
    .prod_data  (prod_data),
    .prod_ready (prod_ready),
    .batch_len  (batch_len),
    .flush      (flush),
    .sum_valid  (sum_valid),
    .sum_data   (sum_data),
    .sum_ready  (sum_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    macc = 0;
    mcnt = 0;
  endtask

  task automatic send(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    prod_data  = d;
    prod_valid = 1'b1;
    #1;
    while (!prod_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("accept_wait", int'(n < 50), 1);
    @(posedge clk);
    if (mcnt == 0)
      mlen = (batch_len == 4'd0) ? 16 : int'(batch_len);
    mcnt++;
    macc += int'(d);
    if (mcnt == mlen) begin
      q.push_back(macc);
      model_clear();
    end
    #1;
    chk("busy_after_accept", int'(busy), 1);
  endtask

  task automatic take_sum();
    int n = 0;
    int exp;
    @(negedge clk);
    prod_valid = 1'b0;
    sum_ready  = 1'b1;
    #1;
    while (!sum_valid && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("sum_wait", int'(sum_valid), 1);
    exp = (q.size() != 0) ? q.pop_front() : -1;
    chk("sum_data", int'(sum_data), exp);
    @(posedge clk);
    #1;
    chk("sum_valid_drop", int'(sum_valid), 0);
    chk("sum_data_hold", int'(sum_data), exp);
    sum_ready = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    prod_valid = 1'b0;
    prod_data  = 8'd0;
    batch_len  = 4'd0;
    flush      = 1'b0;
    sum_ready  = 1'b0;
    #3;
    chk("rst_prod_ready", int'(prod_ready), 1);
    chk("rst_sum_valid", int'(sum_valid), 0);
    chk("rst_sum_data", int'(sum_data), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // two-product batch, continuous valid
    batch_len = 4'd2;
    send(8'd4);
    send(8'd15);
    chk("b2_sum_valid", int'(sum_valid), 1);
    chk("b2_sum_data", int'(sum_data), 19);
    take_sum();

    // sixteen maximal products, no wrap
    batch_len = 4'd0;
    for (int i = 0; i < 16; i++)
      send(8'd225);
    chk("b16_sum_valid", int'(sum_valid), 1);
    take_sum();

    // pending result back-pressures products
    batch_len = 4'd2;
    send(8'd3);
    send(8'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      prod_data  = 8'd9;
      prod_valid = 1'b1;
      #1;
      chk("hold_prod_ready", int'(prod_ready), 0);
      chk("hold_sum_data", int'(sum_data), 7);
    end
    take_sum();
    batch_len = 4'd1;
    send(8'd9);
    take_sum();

    // flush drops partial batch and same-cycle product
    batch_len = 4'd3;
    send(8'd6);
    send(8'd10);
    @(negedge clk);
    flush      = 1'b1;
    prod_valid = 1'b1;
    prod_data  = 8'd7;
    #1;
    chk("flush_prod_ready", int'(prod_ready), 0);
    @(negedge clk);
    flush      = 1'b0;
    prod_valid = 1'b0;
    model_clear();
    #1;
    chk("flush_busy", int'(busy), 0);
    send(8'd1);
    send(8'd2);
    send(8'd3);
    take_sum();

    // asynchronous reset mid-batch
    batch_len = 4'd4;
    send(8'd5);
    send(8'd5);
    @(negedge clk);
    prod_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_sum_valid", int'(sum_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_prod_ready", int'(prod_ready), 1);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++)
      send(8'd5);
    take_sum();

    // batch length frozen after first product
    batch_len = 4'd2;
    send(8'd8);
    batch_len = 4'd5;
    send(8'd9);
    chk("len_latch_sum_valid", int'(sum_valid), 1);
    @(negedge clk);
    prod_valid = 1'b0;
    flush      = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("done_flush_valid", int'(sum_valid), 1);
    chk("done_flush_data", int'(sum_data), 17);
    chk("done_flush_busy", int'(busy), 1);
    take_sum();

    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
